// File: rtl/hv_bundler.sv
// hv_bundler: binds each per-feature level hypervector to its position by a left
// rotation of (feature index mod HV_WIDTH), bundles LANES features per cycle into
// per-bit population counts, then thresholds the counts into one sample hypervector.
//
// Ports
//   clk        rising-edge clock
//   nrst       asynchronous active-low reset
//   en         global enable; low freezes every register
//   hv_in      NUM_FEATURES*HV_WIDTH sample; feature i at [i*HV_WIDTH +: HV_WIDTH]
//   in_valid   hv_in holds a complete sample
//   in_ready   sample can be accepted (idle and enabled)
//   out_hv     thresholded sample hypervector
//   out_valid  out_hv valid; held until out_ready
//   out_ready  consumer accepts out_hv
//   busy       a frame is in flight (accumulate, threshold or output)
module hv_bundler #(
  parameter int unsigned NUM_FEATURES = 617,
  parameter int unsigned HV_WIDTH     = 10,
  parameter int unsigned LANES        = 8,
  parameter int unsigned THRESHOLD    = NUM_FEATURES / 2,
  parameter int unsigned CNT_W        = $clog2(NUM_FEATURES + 1)
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             en,
  input  logic [NUM_FEATURES*HV_WIDTH-1:0] hv_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [HV_WIDTH-1:0]              out_hv,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam int unsigned FIDX_W = $clog2(NUM_FEATURES + LANES + 1);
  localparam int unsigned ROT_W  = (HV_WIDTH > 1) ? $clog2(HV_WIDTH) : 1;
  localparam int unsigned IDX_W  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

  typedef enum logic [1:0] {StIdle, StAccum, StThresh, StOut} state_e;

  state_e              state_q;
  logic [HV_WIDTH-1:0] buf_q     [NUM_FEATURES];
  logic [CNT_W-1:0]    count_q   [HV_WIDTH];
  logic [CNT_W-1:0]    count_sum [HV_WIDTH];
  logic [HV_WIDTH-1:0] bound     [LANES];
  logic [FIDX_W-1:0]   feat_idx_q;
  // Tracks feat_idx_q mod HV_WIDTH so no divider is needed on the feature index.
  logic [ROT_W-1:0]    rot_base_q;
  logic                accept;
  logic                last_beat;

  function automatic logic [HV_WIDTH-1:0] rotl(input logic [HV_WIDTH-1:0] v,
                                               input int unsigned amt);
    logic [2*HV_WIDTH-1:0] d;
    d = {v, v} << amt;
    return d[2*HV_WIDTH-1:HV_WIDTH];
  endfunction

  assign in_ready  = (state_q == StIdle) & en;
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid & in_ready;
  assign last_beat = (32'(feat_idx_q) + LANES) >= NUM_FEATURES;

  // Bound vectors for this beat; lanes past the last feature contribute nothing.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      bound[k] = '0;
      if (32'(feat_idx_q) + k < NUM_FEATURES) begin
        bound[k] = rotl(buf_q[IDX_W'(32'(feat_idx_q) + k)], (32'(rot_base_q) + k) % HV_WIDTH);
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < HV_WIDTH; b++) begin
      count_sum[b] = count_q[b];
      for (int unsigned k = 0; k < LANES; k++) begin
        count_sum[b] = count_sum[b] + CNT_W'(bound[k][b]);
      end
    end
  end

  // Sample snapshot; contents only matter between accept and threshold, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < NUM_FEATURES; i++) begin
        buf_q[i] <= hv_in[i*HV_WIDTH +: HV_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      out_hv     <= '0;
      out_valid  <= 1'b0;
      feat_idx_q <= '0;
      rot_base_q <= '0;
      for (int unsigned b = 0; b < HV_WIDTH; b++) count_q[b] <= '0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            feat_idx_q <= '0;
            rot_base_q <= '0;
            for (int unsigned b = 0; b < HV_WIDTH; b++) count_q[b] <= '0;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          for (int unsigned b = 0; b < HV_WIDTH; b++) count_q[b] <= count_sum[b];
          feat_idx_q <= feat_idx_q + FIDX_W'(LANES);
          rot_base_q <= ROT_W'((32'(rot_base_q) + LANES) % HV_WIDTH);
          if (last_beat) state_q <= StThresh;
        end
        StThresh: begin
          for (int unsigned b = 0; b < HV_WIDTH; b++) out_hv[b] <= 32'(count_q[b]) > THRESHOLD;
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bundler.sv
// Bench for hv_bundler: two instances (default threshold and threshold 61) share all
// inputs; each frame's expected output comes from a per-bit population count model.
module tb_hv_bundler;

  localparam int unsigned NF    = 617;
  localparam int unsigned W     = 10;
  localparam int unsigned L     = 8;
  localparam int unsigned THR_A = NF / 2;
  localparam int unsigned THR_B = 61;
  localparam int          LAT   = (NF + L - 1) / L + 1;

  logic          clk = 1'b0;
  logic          nrst, en, in_valid, out_ready;
  logic [NF*W-1:0] hv_in;
  logic          in_ready_a, out_valid_a, busy_a;
  logic          in_ready_b, out_valid_b, busy_b;
  logic [W-1:0]  out_hv_a, out_hv_b;

  always #5 clk = ~clk;

  hv_bundler #(.NUM_FEATURES(NF), .HV_WIDTH(W), .LANES(L)) dut_a (
    .clk(clk), .nrst(nrst), .en(en), .hv_in(hv_in), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_hv(out_hv_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .busy(busy_a)
  );

  hv_bundler #(.NUM_FEATURES(NF), .HV_WIDTH(W), .LANES(L), .THRESHOLD(THR_B)) dut_b (
    .clk(clk), .nrst(nrst), .en(en), .hv_in(hv_in), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_hv(out_hv_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] feats [NF];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feature f bit j lands on output bit (j + f) mod W after binding.
  function automatic logic [W-1:0] model(input int unsigned thr);
    int unsigned  cnt [W];
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) cnt[b] = 0;
    for (int f = 0; f < NF; f++)
      for (int j = 0; j < W; j++)
        if (feats[f][j]) cnt[(j + f) % W]++;
    for (int b = 0; b < W; b++) r[b] = cnt[b] > thr;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input logic [W-1:0] v);
    for (int f = 0; f < NF; f++) feats[f] = v;
  endtask

  task automatic fill_rand();
    int unsigned p;
    p = $urandom_range(70, 30);
    for (int f = 0; f < NF; f++)
      for (int j = 0; j < W; j++) feats[f][j] = ($urandom_range(99, 0) < p);
  endtask

  task automatic accept(input string tag);
    int n = 0;
    while (!(in_ready_a && in_ready_b) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready_a & in_ready_b}, 32'd1);
    for (int f = 0; f < NF; f++) hv_in[f*W +: W] = feats[f];
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    // Scramble the input bus; the snapshot must be what gets bundled.
    for (int f = 0; f < NF; f++) hv_in[f*W +: W] = W'($urandom);
    chk({tag, "_busy"}, {30'd0, busy_a, busy_b}, 32'd3);
  endtask

  task automatic run_out(input string tag, input int hold, input int gap_at, input int gap_len);
    int           cyc = 0;
    logic         rdy_seen = 1'b0;
    logic [W-1:0] ea, eb;
    ea = model(THR_A);
    eb = model(THR_B);
    while (!out_valid_a && cyc < 300) begin
      if (cyc == gap_at) en = 1'b0;
      if (cyc == gap_at + gap_len) en = 1'b1;
      if (in_ready_a || in_ready_b) rdy_seen = 1'b1;
      step();
      cyc++;
    end
    en = 1'b1;
    chk({tag, "_latency"}, 32'(cyc), 32'(LAT + gap_len));
    chk({tag, "_valid_b"}, {31'd0, out_valid_b}, 32'd1);
    chk({tag, "_rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    chk({tag, "_hv_a"}, {22'd0, out_hv_a}, {22'd0, ea});
    chk({tag, "_hv_b"}, {22'd0, out_hv_b}, {22'd0, eb});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      step();
      chk({tag, "_hold"}, {10'd0, out_valid_a, out_valid_b, out_hv_a, out_hv_b},
          {10'd0, 2'b11, ea, eb});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_done"}, {26'd0, out_valid_a, out_valid_b, in_ready_a, in_ready_b, busy_a, busy_b},
        {26'd0, 6'b001100});
    chk({tag, "_keep"}, {22'd0, out_hv_a}, {22'd0, ea});
  endtask

  initial begin
    nrst      = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hv_in     = '0;
    step();
    step();
    chk("reset_state", {10'd0, out_valid_a, out_valid_b, busy_a, busy_b, out_hv_a, out_hv_b},
        32'd0);
    nrst = 1'b1;
    step();
    chk("reset_ready", {30'd0, in_ready_a, in_ready_b}, 32'd3);

    fill_const(10'h000);
    accept("t1");
    run_out("t1", 0, -1, 0);
    chk("t1_const", {22'd0, out_hv_a}, 32'h000);

    fill_const(10'h3FF);
    accept("t2");
    run_out("t2", 0, -1, 0);
    chk("t2_const", {22'd0, out_hv_a}, 32'h3FF);

    fill_const(10'h001);
    accept("t3");
    run_out("t3", 0, -1, 0);
    chk("t3_const", {22'd0, out_hv_b}, 32'h07F);

    fill_const(10'h3FF);
    accept("t4");
    run_out("t4", 20, -1, 0);

    fill_const(10'h001);
    accept("t5");
    run_out("t5", 0, 30, 5);
    chk("t5_const", {22'd0, out_hv_b}, 32'h07F);

    // Abort a frame mid-accumulation with an asynchronous reset.
    fill_const(10'h3FF);
    accept("t6");
    for (int i = 0; i < 40; i++) step();
    nrst = 1'b0;
    #2;
    chk("t6_rst_async", {10'd0, out_valid_a, out_valid_b, busy_a, busy_b, out_hv_a, out_hv_b},
        32'd0);
    #1;
    nrst = 1'b1;
    step();
    chk("t6_after", {26'd0, out_valid_a, out_valid_b, in_ready_a, in_ready_b, busy_a, busy_b},
        {26'd0, 6'b001100});
    chk("t6_hv_zero", {12'd0, out_hv_a, out_hv_b}, 32'd0);
    accept("t6b");
    run_out("t6b", 0, -1, 0);
    chk("t6b_const", {22'd0, out_hv_a}, 32'h3FF);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      accept("rnd");
      run_out("rnd", int'($urandom_range(3, 0)), -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
